keypad_scan_entry: RTL and testbench

- Input-side counterpart of the team's multiplexed 7-segment scroller: scans a 4x4 matrix keypad, debounces it, and decodes key codes.
- Assembles a two-digit decimal entry (digit_hi, digit_lo). The user-interface top level feeds this entry to the display path as id/remain digits.
- Row outputs are driven one-hot active-low. Column inputs are active-low with board pull-ups.

---
 rtl/keypad_scan_entry_if.sv | 23 ++
 rtl/keypad_scan_entry.sv | 225 ++++++++++++++++++++++
 tb/tb_keypad_scan_entry.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_entry_if.sv
// Keypad scanner bundle: row drive, column sense and decoded entry outputs.
// slave = scanner side, master = keypad/consumer side.
interface keypad_scan_entry_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] digit_hi;
  logic [3:0] digit_lo;
  logic [1:0] entry_cnt;
  logic       entry_done;

  modport slave (
    output row, key_code, key_valid, key_held, digit_hi, digit_lo, entry_cnt, entry_done,
    input  col
  );

  modport master (
    input  row, key_code, key_valid, key_held, digit_hi, digit_lo, entry_cnt, entry_done,
    output col
  );
endinterface

// File: rtl/keypad_scan_entry.sv
// 4x4 matrix keypad scanner with debounce, key decode and two-digit BCD entry.
// Optional macro KEYPAD_REPEAT_EN adds auto-repeat of a held key every REPEAT_TICKS ticks.
module keypad_scan_entry #(
  parameter int SCAN_DIV     = 200000,
  parameter int DB_TICKS     = 4,
  parameter int REPEAT_TICKS = 250
) (
  input logic              clk,
  input logic              rst,
  keypad_scan_entry_if.slave kp
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DB_LAST  = 4'(DB_TICKS - 1);

  localparam logic [1:0] ST_SCAN = 2'd0;
  localparam logic [1:0] ST_DEB  = 2'd1;
  localparam logic [1:0] ST_ACC  = 2'd2;
  localparam logic [1:0] ST_PRS  = 2'd3;

  if (SCAN_DIV < 4 || DB_TICKS < 1 || DB_TICKS > 15 || REPEAT_TICKS < 1) begin : g_bad_param
    $error("keypad_scan_entry: parameter out of range");
  end

  function automatic logic [3:0] rot_row(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  function automatic logic one_low(input logic [3:0] v);
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
      default:                            return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] low_idx(input logic [3:0] v);
    if (!v[0])      return 2'd0;
    else if (!v[1]) return 2'd1;
    else if (!v[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  // Row-major keypad legend; '*' decodes to E and '#' to F.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: return 4'h1;  4'h1: return 4'h2;  4'h2: return 4'h3;  4'h3: return 4'hA;
      4'h4: return 4'h4;  4'h5: return 4'h5;  4'h6: return 4'h6;  4'h7: return 4'hB;
      4'h8: return 4'h7;  4'h9: return 4'h8;  4'hA: return 4'h9;  4'hB: return 4'hC;
      4'hC: return 4'hE;  4'hD: return 4'h0;  4'hE: return 4'hF;  default: return 4'hD;
    endcase
  endfunction

  logic [3:0]       col_m_q, col_s_q;
  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [1:0]       state_q, state_d;
  logic [3:0]       row_q, row_d;
  logic [1:0]       r_q, r_d, c_q, c_d;
  logic [3:0]       pat_q, pat_d;
  logic [3:0]       db_q, db_d, rel_q, rel_d;
  logic [3:0]       code_q, code_d;
  logic             held_q, held_d;
  logic             valid_q, valid_d;
  logic [3:0]       hi_q, lo_q;
  logic [1:0]       cnt_q;
  logic             done_q;

`ifdef KEYPAD_REPEAT_EN
  localparam int             RPT_W    = $clog2(REPEAT_TICKS + 1);
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS - 1);
  logic [RPT_W-1:0] rpt_q, rpt_d;
`endif

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    r_d     = r_q;
    c_d     = c_q;
    pat_d   = pat_q;
    db_d    = db_q;
    rel_d   = rel_q;
    code_d  = code_q;
    held_d  = held_q;
    valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rpt_d   = rpt_q;
`endif
    case (state_q)
      ST_SCAN: if (tick) begin
        if (one_low(col_s_q)) begin
          r_d     = low_idx(row_q);
          c_d     = low_idx(col_s_q);
          pat_d   = col_s_q;
          db_d    = 4'd1;
          state_d = (DB_TICKS == 1) ? ST_ACC : ST_DEB;
        end else begin
          row_d = rot_row(row_q);
        end
      end
      ST_DEB: if (tick) begin
        if (col_s_q == pat_q) begin
          if (db_q == DB_LAST) state_d = ST_ACC;
          else                 db_d    = db_q + 4'd1;
        end else begin
          row_d   = rot_row(row_q);
          state_d = ST_SCAN;
        end
      end
      ST_ACC: begin
        code_d  = key_map(r_q, c_q);
        valid_d = 1'b1;
        held_d  = 1'b1;
        rel_d   = 4'd0;
`ifdef KEYPAD_REPEAT_EN
        rpt_d   = '0;
`endif
        state_d = ST_PRS;
      end
      default: if (tick) begin
        // Row stays parked on the pressed key, so other keys cannot disturb it.
        if (col_s_q == 4'hF) begin
          if (rel_q == DB_LAST) begin
            held_d  = 1'b0;
            row_d   = rot_row(row_q);
            state_d = ST_SCAN;
          end else begin
            rel_d = rel_q + 4'd1;
          end
        end else begin
          rel_d = 4'd0;
        end
`ifdef KEYPAD_REPEAT_EN
        if (col_s_q == pat_q) begin
          if (rpt_q == RPT_LAST) begin
            rpt_d   = '0;
            valid_d = 1'b1;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end else begin
          rpt_d = '0;
        end
`endif
      end
    endcase
  end

  // Stage: synchroniser, tick divider and scan FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_m_q <= 4'hF;
      col_s_q <= 4'hF;
      div_q   <= '0;
      state_q <= ST_SCAN;
      row_q   <= 4'b1110;
      r_q     <= 2'd0;
      c_q     <= 2'd0;
      pat_q   <= 4'hF;
      db_q    <= 4'd0;
      rel_q   <= 4'd0;
      code_q  <= 4'd0;
      held_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= '0;
`endif
    end else begin
      col_m_q <= kp.col;
      col_s_q <= col_m_q;
      div_q   <= tick ? '0 : div_q + 1'b1;
      state_q <= state_d;
      row_q   <= row_d;
      r_q     <= r_d;
      c_q     <= c_d;
      pat_q   <= pat_d;
      db_q    <= db_d;
      rel_q   <= rel_d;
      code_q  <= code_d;
      held_q  <= held_d;
      valid_q <= valid_d;
`ifdef KEYPAD_REPEAT_EN
      rpt_q   <= rpt_d;
`endif
    end
  end

  // Stage: entry register, one cycle behind key_valid
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q   <= 4'd0;
      lo_q   <= 4'd0;
      cnt_q  <= 2'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (valid_q) begin
        if (code_q <= 4'd9) begin
          hi_q  <= lo_q;
          lo_q  <= code_q;
          cnt_q <= (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
        end else if (code_q == 4'hE) begin
          hi_q  <= 4'd0;
          lo_q  <= 4'd0;
          cnt_q <= 2'd0;
        end else if (code_q == 4'hF) begin
          done_q <= 1'b1;
          cnt_q  <= 2'd0;
        end
      end
    end
  end

  assign kp.row        = row_q;
  assign kp.key_code   = code_q;
  assign kp.key_valid  = valid_q;
  assign kp.key_held   = held_q;
  assign kp.digit_hi   = hi_q;
  assign kp.digit_lo   = lo_q;
  assign kp.entry_cnt  = cnt_q;
  assign kp.entry_done = done_q;

endmodule

// File: tb/tb_keypad_scan_entry.sv
// Scoreboard bench for keypad_scan_entry: directed key presses with hand-computed
// expected codes and entry digits, checked by an independent key_valid monitor.
module tb_keypad_scan_entry;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  keypad_scan_entry_if kp();

  keypad_scan_entry #(.SCAN_DIV(4), .DB_TICKS(3), .REPEAT_TICKS(5)) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp.slave)
  );

  // Keypad model: the pressed switch shorts its row to its column.
  int   key_r = 0, key_c = 0;
  logic key_on = 1'b0, dual_on = 1'b0;
  always_comb begin
    kp.col = 4'hF;
    if (key_on && kp.row[key_r] == 1'b0) kp.col[key_c] = 1'b0;
    if (dual_on && kp.row[0] == 1'b0) kp.col[1:0] = 2'b00;
  end

  typedef struct {
    logic [3:0] code;
    logic [3:0] hi;
    logic [3:0] lo;
    logic [1:0] cnt;
    logic       done;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0, vcount = 0;

  function automatic exp_t mk(input logic [3:0] code, hi, lo, input logic [1:0] cnt,
                              input logic done);
    exp_t e;
    e.code = code; e.hi = hi; e.lo = lo; e.cnt = cnt; e.done = done;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per key_valid, checks entry outputs one cycle later.
  exp_t cur;
  logic pend = 1'b0;
  always @(negedge clk) begin
    if (pend) begin
      chk("digit_hi", kp.digit_hi, cur.hi);
      chk("digit_lo", kp.digit_lo, cur.lo);
      chk("entry_cnt", kp.entry_cnt, cur.cnt);
      chk("entry_done", kp.entry_done, cur.done);
      pend = 1'b0;
    end
    if (rst && kp.key_valid) begin
      vcount++;
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_key_valid: got code %0h expected no key_valid", kp.key_code);
      end else begin
        cur = q.pop_front();
        chk("key_code", kp.key_code, cur.code);
        chk("key_held_at_valid", kp.key_held, 1);
        pend = 1'b1;
      end
    end
  end

  task automatic wait_valid(input string name, input int limit, output int n);
    int vc0;
    vc0 = vcount;
    n = 0;
    while (vcount == vc0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk(name, (vcount != vc0), 1);
  endtask

  task automatic wait_row(input logic [3:0] val, input string name);
    int n;
    n = 0;
    while (kp.row !== val && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(name, kp.row, val);
  endtask

  task automatic release_key(input int r);
    int n;
    logic [3:0] nxt;
    n = 0;
    nxt = ~(4'b0001 << ((r + 1) % 4));
    key_on = 1'b0;
    repeat (8) @(negedge clk);
    chk("held_after_release", kp.key_held, 1);
    while (kp.key_held && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("held_drop", kp.key_held, 0);
    chk("row_resume", kp.row, nxt);
  endtask

  task automatic press_key(input int r, input int c, input exp_t e, input int hold);
    int n;
    q.push_back(e);
    key_r = r;
    key_c = c;
    key_on = 1'b1;
    wait_valid("valid_timeout", 80, n);
    repeat (hold) @(negedge clk);
    release_key(r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int n, vc0;
    logic [3:0] exp_row;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_row", kp.row, 4'b1110);
    chk("rst_key_code", kp.key_code, 0);
    chk("rst_key_valid", kp.key_valid, 0);
    chk("rst_key_held", kp.key_held, 0);
    chk("rst_digit_hi", kp.digit_hi, 0);
    chk("rst_digit_lo", kp.digit_lo, 0);
    chk("rst_entry_cnt", kp.entry_cnt, 0);
    chk("rst_entry_done", kp.entry_done, 0);

    // Idle rotation: one row step every 4 clocks
    rst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      exp_row = 4'b1110;
      for (int s = 0; s < (k / 4) % 4; s++) exp_row = {exp_row[2:0], exp_row[3]};
      chk("idle_rotation", kp.row, exp_row);
    end
    chk("idle_no_valid", vcount, 0);

    // '5' held then released
    press_key(1, 1, mk(4'h5, 4'h0, 4'h5, 2'd1, 1'b0), 20);

    // Bouncing '7'
    q.push_back(mk(4'h7, 4'h5, 4'h7, 2'd2, 1'b0));
    key_r = 2;
    key_c = 0;
    vc0 = vcount;
    for (int i = 0; i < 6; i++) begin
      key_on = (i % 2 == 0);
      repeat (4) @(negedge clk);
    end
    chk("bounce_no_valid", vcount - vc0, 0);
    key_on = 1'b1;
    wait_valid("bounce_valid_timeout", 60, n);
    chk("bounce_latency", (n >= 8 && n <= 36), 1);
    repeat (8) @(negedge clk);
    release_key(2);

    // 4, 2, A, '#'
    press_key(1, 0, mk(4'h4, 4'h7, 4'h4, 2'd2, 1'b0), 8);
    press_key(0, 1, mk(4'h2, 4'h4, 4'h2, 2'd2, 1'b0), 8);
    press_key(0, 3, mk(4'hA, 4'h4, 4'h2, 2'd2, 1'b0), 8);
    press_key(3, 2, mk(4'hF, 4'h4, 4'h2, 2'd0, 1'b1), 8);

    // Two columns low on r0: rejected, rotation continues
    vc0 = vcount;
    dual_on = 1'b1;
    wait_row(4'b0111, "dual_reach_r3");
    wait_row(4'b1110, "dual_reach_r0");
    repeat (4) @(negedge clk);
    chk("dual_rotation", kp.row, 4'b1101);
    repeat (32) @(negedge clk);
    chk("dual_no_valid", vcount - vc0, 0);
    dual_on = 1'b0;

    // Reset while '1' is being debounced; key stays down and is re-accepted
    wait_row(4'b1101, "pre_rst_r1");
    key_r = 0;
    key_c = 0;
    key_on = 1'b1;
    vc0 = vcount;
    wait_row(4'b1110, "pre_rst_r0");
    repeat (6) @(negedge clk);
    chk("deb_held", kp.key_held, 0);
    chk("deb_no_valid", vcount - vc0, 0);
    q.push_back(mk(4'h1, 4'h0, 4'h1, 2'd1, 1'b0));
    rst = 1'b0;
    #1;
    chk("mid_rst_row", kp.row, 4'b1110);
    chk("mid_rst_key_code", kp.key_code, 0);
    chk("mid_rst_held", kp.key_held, 0);
    chk("mid_rst_digit_hi", kp.digit_hi, 0);
    chk("mid_rst_digit_lo", kp.digit_lo, 0);
    @(negedge clk);
    rst = 1'b1;
    wait_valid("after_rst_valid_timeout", 80, n);
    repeat (8) @(negedge clk);
    release_key(0);

    // '*' clears, then '9' held for 16 ticks after accept
    press_key(3, 0, mk(4'hE, 4'h0, 4'h0, 2'd0, 1'b0), 8);
    vc0 = vcount;
`ifdef KEYPAD_REPEAT_EN
    q.push_back(mk(4'h9, 4'h0, 4'h9, 2'd1, 1'b0));
    q.push_back(mk(4'h9, 4'h9, 4'h9, 2'd2, 1'b0));
    q.push_back(mk(4'h9, 4'h9, 4'h9, 2'd2, 1'b0));
    press_key(2, 2, mk(4'h9, 4'h9, 4'h9, 2'd2, 1'b0), 64);
    chk("hold9_valid_count", vcount - vc0, 4);
`else
    press_key(2, 2, mk(4'h9, 4'h0, 4'h9, 2'd1, 1'b0), 64);
    chk("hold9_valid_count", vcount - vc0, 1);
`endif

    repeat (4) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
